// File: rtl/ret_stack_if.sv
// Push/pop bus between the prefetch stage and the return-address stack.
// Error flags ovf/unf exist only when RET_STACK_ERR_EN is defined.
interface ret_stack_if #(
    parameter int MINSTW = 8,
    parameter int SPTRW  = 3
);
    logic              push;
    logic              pop;
    logic [MINSTW-1:0] d;
    logic [MINSTW-1:0] q;
    logic              empty;
    logic              full;
    logic [SPTRW:0]    count;
`ifdef RET_STACK_ERR_EN
    logic              ovf;
    logic              unf;
`endif

    modport master (
        output push, pop, d,
`ifdef RET_STACK_ERR_EN
        input  ovf, unf,
`endif
        input  q, empty, full, count
    );

    modport slave (
        input  push, pop, d,
`ifdef RET_STACK_ERR_EN
        output ovf, unf,
`endif
        output q, empty, full, count
    );
endinterface

// File: rtl/ret_stack.sv
// Circular return-address LIFO; top of stack is combinational (zero latency), never stalls:
// push when full overwrites the oldest entry. RET_STACK_ERR_EN adds sticky ovf/unf flags.
module ret_stack #(
    parameter int MINSTW = 8,
    parameter int SPTRW  = 3
) (
    input  logic         clk,
    input  logic         rst,
    ret_stack_if.slave   bus
);
    localparam int             DEPTH   = 2 ** SPTRW;
    localparam logic [SPTRW:0] W_DEPTH = (SPTRW + 1)'(DEPTH);

    logic [MINSTW-1:0] r_mem [DEPTH];
    logic [SPTRW-1:0]  r_sp;
    logic [SPTRW:0]    r_count;

    logic              w_empty;
    logic              w_full;
    logic              w_replace;
    logic              w_push_only;
    logic              w_pop_only;
    logic [SPTRW-1:0]  w_top_idx;
    logic [SPTRW-1:0]  w_wr_idx;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == W_DEPTH);
    assign w_top_idx   = r_sp - SPTRW'(1);
    // push+pop on an empty stack degenerates to a plain push
    assign w_replace   = bus.push && bus.pop && !w_empty;
    assign w_push_only = bus.push && !w_replace;
    assign w_pop_only  = bus.pop && !bus.push && !w_empty;
    assign w_wr_idx    = w_replace ? w_top_idx : r_sp;

    always_ff @(posedge clk) begin
        if (rst && bus.push) begin
            r_mem[w_wr_idx] <= bus.d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sp    <= '0;
            r_count <= '0;
        end else if (w_push_only) begin
            r_sp    <= r_sp + SPTRW'(1);
            r_count <= w_full ? r_count : r_count + (SPTRW + 1)'(1);
        end else if (w_pop_only) begin
            r_sp    <= w_top_idx;
            r_count <= r_count - (SPTRW + 1)'(1);
        end
    end

    assign bus.q     = w_empty ? '0 : r_mem[w_top_idx];
    assign bus.empty = w_empty;
    assign bus.full  = w_full;
    assign bus.count = r_count;

`ifdef RET_STACK_ERR_EN
    logic r_ovf;
    logic r_unf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (bus.push && !bus.pop && w_full) r_ovf <= 1'b1;
            if (bus.pop && w_empty)             r_unf <= 1'b1;
        end
    end

    assign bus.ovf = r_ovf;
    assign bus.unf = r_unf;
`endif
endmodule

// File: tb/tb_ret_stack.sv
// Directed vector table plus randomized traffic against a queue-based LIFO model.
module tb_ret_stack;
    localparam int DEPTH = 8;

    typedef struct {
        bit       rst_n;
        bit       push;
        bit       pop;
        bit [7:0] d;
        bit       chk_qb;
        bit [7:0] qb;
        int       cnt;
        bit [7:0] qa;
        bit       ovf;
        bit       unf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_tot;
    int   n_bad;
    vec_t vecs[$];

    bit [7:0] mdl[$];
    bit       m_ovf;
    bit       m_unf;

    ret_stack_if #(.MINSTW(8), .SPTRW(3)) bus ();

    ret_stack #(.MINSTW(8), .SPTRW(3)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void add(bit r, bit pu, bit po, bit [7:0] d, bit cq, bit [7:0] qb,
                                int cnt, bit [7:0] qa, bit ov, bit un);
        vec_t v;
        v.rst_n = r; v.push = pu; v.pop = po; v.d = d; v.chk_qb = cq; v.qb = qb;
        v.cnt = cnt; v.qa = qa; v.ovf = ov; v.unf = un;
        vecs.push_back(v);
    endfunction

    // Inputs are applied just after a falling edge; q is checked before the
    // rising edge, registered state one time unit after it.
    task automatic apply(input vec_t v);
        rst      = v.rst_n;
        bus.push = v.push;
        bus.pop  = v.pop;
        bus.d    = v.d;
        #1;
        if (v.chk_qb) chk("q_during", bus.q, v.qb);
        @(posedge clk);
        #1;
        chk("count", bus.count, v.cnt);
        chk("empty", bus.empty, v.cnt == 0);
        chk("full",  bus.full,  v.cnt == DEPTH);
        chk("q_after", bus.q, v.qa);
`ifdef RET_STACK_ERR_EN
        chk("ovf", bus.ovf, v.ovf);
        chk("unf", bus.unf, v.unf);
`endif
        @(negedge clk);
    endtask

    function automatic bit [7:0] mdl_top();
        return (mdl.size() > 0) ? mdl[mdl.size()-1] : 8'h00;
    endfunction

    function automatic void mdl_step(bit r, bit pu, bit po, bit [7:0] d);
        if (!r) begin
            mdl.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            if (po && mdl.size() == 0) m_unf = 1;
            if (pu && !po && mdl.size() == DEPTH) m_ovf = 1;
            if (pu && po && mdl.size() > 0) begin
                mdl[mdl.size()-1] = d;
            end else if (pu) begin
                mdl.push_back(d);
                if (mdl.size() > DEPTH) void'(mdl.pop_front());
            end else if (po && mdl.size() > 0) begin
                void'(mdl.pop_back());
            end
        end
    endfunction

    initial begin
        vec_t v;
        n_tot = 0;
        n_bad = 0;
        rst = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.d = 8'h00;

        // reset held two cycles with a push pending
        add(0,1,0,8'h55, 0,8'h00, 0,8'h00, 0,0);
        add(0,1,0,8'h55, 1,8'h00, 0,8'h00, 0,0);
        // basic LIFO
        add(1,1,0,8'h10, 1,8'h00, 1,8'h10, 0,0);
        add(1,1,0,8'h20, 1,8'h10, 2,8'h20, 0,0);
        add(1,1,0,8'h30, 1,8'h20, 3,8'h30, 0,0);
        add(1,0,1,8'h00, 1,8'h30, 2,8'h20, 0,0);
        add(1,0,1,8'h00, 1,8'h20, 1,8'h10, 0,0);
        add(1,0,1,8'h00, 1,8'h10, 0,8'h00, 0,0);
        // fill past capacity: ninth push overwrites the oldest
        for (int k = 1; k <= 9; k++)
            add(1,1,0,8'(k), 1,8'(k-1), (k > DEPTH) ? DEPTH : k, 8'(k), k == 9, 0);
        for (int j = 0; j < 8; j++)
            add(1,0,1,8'h00, 1,8'(9-j), 7-j, (j == 7) ? 8'h00 : 8'(8-j), 1, 0);
        add(0,0,0,8'h00, 1,8'h00, 0,8'h00, 0,0);
        // replace top
        add(1,1,0,8'hA0, 1,8'h00, 1,8'hA0, 0,0);
        add(1,1,0,8'hB0, 1,8'hA0, 2,8'hB0, 0,0);
        add(1,1,1,8'hC0, 1,8'hB0, 2,8'hC0, 0,0);
        add(1,0,1,8'h00, 1,8'hC0, 1,8'hA0, 0,0);
        add(1,0,1,8'h00, 1,8'hA0, 0,8'h00, 0,0);
        // underflow, then push+pop on empty
        add(0,0,0,8'h00, 1,8'h00, 0,8'h00, 0,0);
        add(1,0,1,8'h00, 1,8'h00, 0,8'h00, 0,1);
        add(1,1,1,8'h7E, 1,8'h00, 1,8'h7E, 0,1);
        // reset mid-operation clears entries and sticky flags
        add(0,0,0,8'h00, 1,8'h7E, 0,8'h00, 0,0);
        add(1,0,1,8'h00, 1,8'h00, 0,8'h00, 0,1);
        add(1,1,0,8'h11, 1,8'h00, 1,8'h11, 0,1);
        add(1,1,0,8'h22, 1,8'h11, 2,8'h22, 0,1);
        add(1,1,0,8'h33, 1,8'h22, 3,8'h33, 0,1);
        add(0,0,1,8'h00, 1,8'h33, 0,8'h00, 0,0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // randomized traffic against the model; the model starts from the reset above
        mdl.delete(); m_ovf = 0; m_unf = 0;
        for (int i = 0; i < 600; i++) begin
            v.rst_n  = ($urandom_range(0, 59) != 0);
            v.push   = ($urandom_range(0, 99) < 55);
            v.pop    = ($urandom_range(0, 99) < 45);
            v.d      = 8'($urandom);
            v.chk_qb = 1;
            v.qb     = mdl_top();
            mdl_step(v.rst_n, v.push, v.pop, v.d);
            v.cnt    = mdl.size();
            v.qa     = mdl_top();
            v.ovf    = m_ovf;
            v.unf    = m_unf;
            apply(v);
        end

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
